// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types and helpers used by the multiplier and divider.
// Combinational helpers only; no state.
package arith_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    // Conditional two's-complement negate; callers truncate to their own width.
    function automatic logic [63:0] neg_cond(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bundle of the sequential signed divider.
// master drives the request side, slave is the divider.
interface seq_signed_divider_if #(parameter int WIDTH = arith_pkg::DIV_WIDTH);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ovf;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, ovf, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, ovf, div_zero
    );

endinterface

// File: rtl/div_substep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Purely combinational; no handshake.
module div_substep #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One extra bit above the shifted remainder makes the borrow a plain sign bit.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, dvsr};
    assign q_bit   = ~diff[WIDTH+1];
    assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential truncating signed divider, one quotient bit per clock (DIV_ZERO_DETECT_EN adds zero-divisor shortcut).
// Latency: done in the cycle after WIDTH+2 edges counting the accepting edge (1 edge for a detected zero divisor).
// Backpressure: start is taken only while ready (IDLE/DONE); requests while busy are dropped.
module seq_signed_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_nxt;
    logic             ready;
    logic             done;

    logic [WIDTH-1:0] dvd_q;      // dividend magnitude shifts out the top, quotient bits enter the bottom
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH:0]   prem;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             ovf_case;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             ovf_r;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvsr_abs;
    logic [WIDTH:0]   prem_nxt;
    logic             q_bit;

`ifdef DIV_ZERO_DETECT_EN
    logic             dvsr_zero;
    logic             div_zero_r;
    assign dvsr_zero = (bus.divisor == '0);
`endif

    assign dvd_abs  = WIDTH'(neg_cond(64'(bus.dividend), bus.dividend[WIDTH-1]));
    assign dvsr_abs = WIDTH'(neg_cond(64'(bus.divisor), bus.divisor[WIDTH-1]));

    div_substep #(.WIDTH(WIDTH)) u_substep (
        .rem_in  (prem),
        .bit_in  (dvd_q[WIDTH-1]),
        .dvsr    (dvsr_mag),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                ready = 1'b1;
                done  = (state == DONE);
                if (bus.start) begin
`ifdef DIV_ZERO_DETECT_EN
                    state_nxt = dvsr_zero ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvsr_mag    <= '0;
            prem        <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_case    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ovf_r       <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
`ifdef DIV_ZERO_DETECT_EN
                        if (dvsr_zero) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            ovf_r       <= 1'b0;
                            div_zero_r  <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            dvd_q    <= dvd_abs;
                            dvsr_mag <= dvsr_abs;
                            sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_r   <= bus.dividend[WIDTH-1];
                            ovf_case <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                            prem     <= '0;
                            cnt      <= '0;
                        end
                    end
                end
                CALC: begin
                    prem  <= prem_nxt;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                    cnt   <= cnt + CW'(1);
                end
                FIXUP: begin
                    // MIN/-1 gives magnitude 2^(W-1), which already wraps to MIN with remainder 0.
                    quotient_r  <= WIDTH'(neg_cond(64'(dvd_q), sign_q));
                    remainder_r <= WIDTH'(neg_cond(64'(prem[WIDTH-1:0]), sign_r));
                    ovf_r       <= ovf_case;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_r  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = ready;
    assign bus.done      = done;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.ovf       = ovf_r;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = div_zero_r;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule
